// File: rtl/serial_add_seq.sv
// serial_add_seq - bit-serial adder sequencer.
//
// Accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake,
// then adds them one bit pair per clock through a single full-adder cell. The
// full-adder carry-out is registered and fed back as the next carry-in. After
// WIDTH cycles the sum, carry-out and signed overflow are presented to the
// consumer with valid/ready and held until taken.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      operands a/b/cin valid
//   in_ready   out  1      block can accept operands (IDLE and not in reset)
//   a          in   WIDTH  operand A (unsigned or two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in for the LSB
//   out_valid  out  1      sum/cout/ovf valid
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
//   cout       out  1      carry out of the MSB
//   ovf        out  1      signed overflow (carry into MSB xor carry out of MSB)

// Single-bit full adder used as the serial arithmetic element.
module fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    // Holds the WIDTH-1 sum bits produced so far; the final bit is merged
    // in directly when the result is captured.
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic             fa_s;
    logic             fa_c;
    logic             last_bit;
    logic             accept;

    fa u_fa (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    assign in_ready  = (state == IDLE) & rst_n;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid & in_ready;
    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign sum_next  = {fa_s, sum_sr};

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // State register; reset drops any transaction in flight, which also
    // removes out_valid immediately since it is decoded from the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, WIDTH serial cycles in RUN, then
    // wait in HOLD until the consumer takes the result.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = RUN;
            RUN:  if (last_bit) next_state = HOLD;
            HOLD: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Serial datapath. Operands are captured only on the accept edge; during
    // RUN both operands shift right so bit 0 always feeds the adder. On the
    // final bit the carry register still holds the carry into the MSB, which
    // gives the signed overflow when xored with the MSB carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    sum_sr <= sum_next[WIDTH-1:1];
                    carry  <= fa_c;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_q  <= sum_next;
                        cout_q <= fa_c;
                        ovf_q  <= carry ^ fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
